// File: rtl/lcd_spi_capture.sv
// SPI target for the LCD link: oversamples SCK/COPI/CS/DC, rebuilds bytes,
// tags each with its D/C bit and queues {dc, byte} entries for readout.
module lcd_spi_capture #(
    parameter int FifoDepth  = 8,
    parameter int SyncStages = 2
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_sys_ni,
    input  logic                           spi_sck_i,
    input  logic                           spi_cs_ni,
    input  logic                           spi_copi_i,
    input  logic                           spi_dc_i,
    output logic [8:0]                     rd_data_o,
    output logic                           rd_valid_o,
    input  logic                           rd_ready_i,
    output logic [$clog2(FifoDepth):0]     fifo_level_o,
    output logic                           busy_o,
    output logic                           frame_err_o,
    output logic                           overflow_o,
    input  logic                           clr_overflow_i,
    output logic                           dbg_state_o
);

    localparam int PtrW    = $clog2(FifoDepth);
    localparam int LvlW    = PtrW + 1;
    localparam int SettleW = $clog2(SyncStages + 2);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(SyncStages + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers; reset values match the idle pin levels.
    // ------------------------------------------------------------------
    logic [SyncStages-1:0] sck_sync;
    logic [SyncStages-1:0] cs_sync;
    logic [SyncStages-1:0] copi_sync;
    logic [SyncStages-1:0] dc_sync;
    logic                  sck_q;
    logic                  cs_q;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            dc_sync   <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
            cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
            copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
            dc_sync   <= {dc_sync[SyncStages-2:0], spi_dc_i};
            sck_q     <= sck_sync[SyncStages-1];
            cs_q      <= cs_sync[SyncStages-1];
        end
    end

    logic sync_sck;
    logic sync_cs;
    logic sync_copi;
    logic sync_dc;
    logic sck_rise;
    logic cs_fall;
    logic cs_rise;

    assign sync_sck  = sck_sync[SyncStages-1];
    assign sync_cs   = cs_sync[SyncStages-1];
    assign sync_copi = copi_sync[SyncStages-1];
    assign sync_dc   = dc_sync[SyncStages-1];
    assign sck_rise  = sync_sck & ~sck_q;
    assign cs_fall   = ~sync_cs & cs_q;
    assign cs_rise   = sync_cs & ~cs_q;

    // ------------------------------------------------------------------
    // Frame-start arming. The synchroniser resets to CS high, so a pin
    // that is already low at reset release would look like a falling
    // edge. A frame may only start once CS has been seen genuinely high
    // after the chain has flushed its reset values.
    // ------------------------------------------------------------------
    logic [SettleW-1:0] settle_cnt;
    logic               cs_armed;
    logic               settled;

    assign settled = (settle_cnt == SettleMax);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            settle_cnt <= '0;
            cs_armed   <= 1'b0;
        end else begin
            if (!settled) begin
                settle_cnt <= settle_cnt + SettleW'(1);
            end
            if (!cs_armed && settled && sync_cs && cs_q) begin
                cs_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte assembly FSM. Only the low 7 shifted bits are kept: the 8th
    // bit goes straight from the synchroniser into the pushed entry.
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic [6:0] shift_q;
    logic [6:0] shift_d;
    logic       push_req;
    logic [8:0] push_word;
    logic       frame_err_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        push_word   = {sync_dc, shift_q, sync_copi};
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_fall && cs_armed) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A CS release takes priority over a coincident SCK edge.
                if (cs_rise) begin
                    state_d     = IDLE;
                    bit_cnt_d   = 3'd0;
                    frame_err_d = (bit_cnt_q != 3'd0);
                end else if (sck_rise) begin
                    shift_d   = {shift_q[5:0], sync_copi};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    push_req  = (bit_cnt_q == 3'd7);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic       push_q;
    logic [8:0] push_data_q;
    logic       frame_err_q;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            push_q      <= 1'b0;
            push_data_q <= 9'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_req;
            push_data_q <= push_word;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy_o      = (state_q == SHIFT);
    assign frame_err_o = frame_err_q;
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Readout FIFO. Handshake: rd_valid_o is high whenever an entry is
    // queued and rd_data_o holds the head; the head is consumed on a
    // clock edge where rd_valid_o && rd_ready_i, and rd_ready_i has no
    // effect while rd_valid_o is low.
    // ------------------------------------------------------------------
    logic [8:0]      mem [FifoDepth];
    logic [PtrW:0]   wr_ptr;
    logic [PtrW:0]   rd_ptr;
    logic [LvlW-1:0] level;
    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            drop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == LvlW'(FifoDepth));
    assign do_pop  = ~empty & rd_ready_i;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_push = push_q & (~full | do_pop);
    assign drop    = push_q & full & ~do_pop;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= 9'd0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PtrW-1:0]] <= push_data_q;
                wr_ptr                <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clr_overflow_i) begin
            overflow_o <= 1'b0;
        end
    end

    assign rd_data_o    = mem[rd_ptr[PtrW-1:0]];
    assign rd_valid_o   = ~empty;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_lcd_spi_capture.sv
// Directed bench for lcd_spi_capture: bit-bangs mode-0 SPI frames and checks
// captured entries, latency, frame errors, overflow and reset behaviour.
module tb_lcd_spi_capture;

    localparam int SS    = 2;
    localparam int DEPTH = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       sck      = 1'b0;
    logic       cs_n     = 1'b1;
    logic       copi     = 1'b0;
    logic       dc       = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_ovf  = 1'b0;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic [3:0] level;
    logic       busy;
    logic       ferr;
    logic       ovf;
    logic       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_count = 0;

    lcd_spi_capture #(.FifoDepth(DEPTH), .SyncStages(SS)) dut (
        .clk_sys_i      (clk),
        .rst_sys_ni     (rst_n),
        .spi_sck_i      (sck),
        .spi_cs_ni      (cs_n),
        .spi_copi_i     (copi),
        .spi_dc_i       (dc),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .fifo_level_o   (level),
        .busy_o         (busy),
        .frame_err_o    (ferr),
        .overflow_o     (ovf),
        .clr_overflow_i (clr_ovf),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr === 1'b1) fe_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sck_rise(input logic b, input logic d);
        copi = b;
        dc   = d;
        repeat (4) tick();
        sck = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sck_rise(b[i], d);
            repeat (4) tick();
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_high();
        repeat (4) tick();
        cs_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic do_pop(output logic [8:0] d, output logic v);
        v        = rd_valid;
        d        = rd_data;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 9'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", rd_data); end
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", ferr); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        rst_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_single_byte();
        int fe0;
        logic [8:0] d;
        logic v;
        fe0 = fe_count;
        cs_low();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        send_bits(8'hA5, 1'b1, 7);
        sck_rise(1'b1, 1'b1);
        repeat (SS + 1) tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: got %b want 0", rd_valid); end
        tick();
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b want 1", rd_valid); end
        sck = 1'b0;
        cs_high();
        n_checks++; if (rd_data !== 9'h1A5) begin n_fail++; $display("FAIL single_data: got %h want 1a5", rd_data); end
        n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", busy); end
        n_checks++; if (fe_count != fe0) begin n_fail++; $display("FAIL single_no_frame_err: got %0d pulses want 0", fe_count - fe0); end
        do_pop(d, v);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", rd_valid); end
    endtask

    task automatic test_multi_byte();
        logic [8:0] d;
        logic v;
        logic [8:0] exp_vals [3];
        exp_vals = '{9'h02A, 9'h100, 9'h17F};
        cs_low();
        send_bits(8'h2A, 1'b0, 8);
        send_bits(8'h00, 1'b1, 8);
        send_bits(8'h7F, 1'b1, 8);
        cs_high();
        n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL multi_level: got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            do_pop(d, v);
            n_checks++; if (v !== 1'b1 || d !== exp_vals[i]) begin n_fail++; $display("FAIL multi_pop%0d: got %h (valid %b) want %h", i, d, v, exp_vals[i]); end
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL multi_empty: got %b want 0", rd_valid); end
    endtask

    task automatic test_aborted_byte();
        int fe0;
        logic [8:0] d;
        logic v;
        fe0 = fe_count;
        cs_low();
        send_bits(8'hFF, 1'b1, 5);
        cs_high();
        n_checks++; if (fe_count - fe0 != 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d cycles want 1", fe_count - fe0); end
        n_checks++; if (rd_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL abort_empty: got valid %b level %0d want 0/0", rd_valid, level); end
        cs_low();
        send_bits(8'h3C, 1'b0, 8);
        cs_high();
        do_pop(d, v);
        n_checks++; if (v !== 1'b1 || d !== 9'h03C) begin n_fail++; $display("FAIL abort_next_byte: got %h (valid %b) want 03c", d, v); end
        n_checks++; if (fe_count - fe0 != 1) begin n_fail++; $display("FAIL abort_no_extra_err: got %0d cycles want 1", fe_count - fe0); end
    endtask

    task automatic test_overflow();
        logic [8:0] d;
        logic v;
        rd_ready = 1'b0;
        cs_low();
        for (int i = 1; i <= 9; i++) send_bits(8'(i), 1'b0, 8);
        cs_high();
        n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", level); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        // Clear lands in the very cycle of another drop.
        cs_low();
        send_bits(8'h0A, 1'b0, 7);
        sck_rise(1'b0, 1'b0);
        repeat (SS + 1) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop: got %b want 1", ovf); end
        sck = 1'b0;
        cs_high();
        n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level_after_drop: got %0d want 8", level); end
        for (int i = 1; i <= 8; i++) begin
            do_pop(d, v);
            n_checks++; if (v !== 1'b1 || d !== 9'(i)) begin n_fail++; $display("FAIL ovf_pop%0d: got %h (valid %b) want %h", i, d, v, 9'(i)); end
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", rd_valid); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic test_full_with_pop();
        logic [8:0] d;
        logic v;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_pre_ovf: got %b want 0", ovf); end
        cs_low();
        for (int i = 0; i < 8; i++) send_bits(8'h10 + 8'(i), 1'b1, 8);
        send_bits(8'h55, 1'b0, 7);
        sck_rise(1'b1, 1'b0);
        repeat (SS + 1) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        sck = 1'b0;
        cs_high();
        n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fullpop_level: got %0d want 8", level); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
        for (int i = 1; i < 8; i++) begin
            do_pop(d, v);
            n_checks++; if (v !== 1'b1 || d !== (9'h110 + 9'(i))) begin n_fail++; $display("FAIL fullpop_pop%0d: got %h (valid %b) want %h", i, d, v, 9'h110 + 9'(i)); end
        end
        do_pop(d, v);
        n_checks++; if (v !== 1'b1 || d !== 9'h055) begin n_fail++; $display("FAIL fullpop_last: got %h (valid %b) want 055", d, v); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", rd_valid); end
    endtask

    task automatic test_reset_mid_byte();
        int fe0;
        logic [8:0] d;
        logic v;
        cs_low();
        send_bits(8'h99, 1'b1, 8);
        send_bits(8'hF0, 1'b1, 4);
        n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL rstmid_pre_level: got %0d want 1", level); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (level !== 4'd0 || rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_clear: got level %0d valid %b busy %b want 0/0/0", level, rd_valid, busy); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        fe0 = fe_count;
        send_bits(8'hFF, 1'b1, 8);
        repeat (4) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_frame: got busy %b want 0", busy); end
        n_checks++; if (rd_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL rstmid_no_capture: got valid %b level %0d want 0/0", rd_valid, level); end
        cs_n = 1'b1;
        repeat (8) tick();
        n_checks++; if (fe_count != fe0) begin n_fail++; $display("FAIL rstmid_no_frame_err: got %0d pulses want 0", fe_count - fe0); end
        cs_low();
        send_bits(8'hC3, 1'b1, 8);
        cs_high();
        do_pop(d, v);
        n_checks++; if (v !== 1'b1 || d !== 9'h1C3) begin n_fail++; $display("FAIL rstmid_next_byte: got %h (valid %b) want 1c3", d, v); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_aborted_byte();
        test_overflow();
        test_full_with_pop();
        test_reset_mid_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_spi_capture.md
Name: lcd_spi_capture

Overview:
- SPI target that receives the LCD link (SCK/COPI/CS/DC) driven by the Sonata LCD controller path.
- Deserialises bytes, tags each with its D/C bit, and queues them in a FIFO for readout.
- Used on-FPGA as a loopback/monitor, so software and benches can check what the LCD actually received.
- Runs entirely in the clk_sys_i domain; all SPI pins are treated as asynchronous and oversampled.

Parameters:
- FifoDepth, 8, number of queued 9-bit entries; must be a power of 2, ≥2.
- SyncStages, 2, synchroniser flops per SPI input; must be ≥2.

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  asynchronous active-low reset.
- spi_sck_i  input  1  SPI clock, mode 0 (idle low, sample on rising edge).
- spi_cs_ni  input  1  chip select, active low.
- spi_copi_i  input  1  serial data, MSB first.
- spi_dc_i  input  1  LCD data/command flag (1 = data).
- rd_data_o  output  9  {dc, byte[7:0]} at FIFO head.
- rd_valid_o  output  1  FIFO non-empty.
- rd_ready_i  input  1  pop head when rd_valid_o & rd_ready_i.
- fifo_level_o  output  $clog2(FifoDepth)+1  current entry count.
- busy_o  output  1  synchronised CS is asserted.
- frame_err_o  output  1  one-cycle pulse: CS released mid-byte.
- overflow_o  output  1  sticky: a byte was dropped because the FIFO was full.
- clr_overflow_i  input  1  clears overflow_o.

Behaviour:
- Reset values:
  - Outputs: rd_valid_o=0, rd_data_o=0, fifo_level_o=0, busy_o=0, frame_err_o=0, overflow_o=0.
  - Internal state: bit_cnt=0, shift=0, FIFO pointers 0.
  - Synchroniser flops reset to the idle pin levels: sck=0, cs_n=1, copi=0, dc=0.
- Input conditioning:
  - Each SPI input passes through SyncStages flops.
  - A further register on sck and cs_n gives edge detection.
  - sck_rise = sync_sck & ~sck_q; cs_fall and cs_rise are detected the same way.
- Timing constraint: SCK high and low phases must each be ≥3 clk_sys_i cycles. Behaviour outside this constraint is undefined; the bench must not violate it.
- State machine:
  - IDLE (cs high): busy_o=0, bit_cnt held at 0.
    - cs_fall → SHIFT, bit_cnt=0.
  - SHIFT (cs low): busy_o=1.
    - On sck_rise: shift={shift[6:0], sync_copi}, bit_cnt++.
    - On the 8th sck_rise (bit_cnt 7→0): push {sync_dc, shift[6:0], sync_copi} the same cycle; stay in SHIFT for the next byte.
    - cs_rise → IDLE. If bit_cnt≠0, the partial byte is discarded, frame_err_o pulses for 1 cycle, and bit_cnt=0.
    - cs_rise and sck_rise in the same cycle: CS wins. The edge is ignored and the frame check uses bit_cnt before the edge.
- DC is sampled at the 8th SCK rising edge only.
- Latency: rd_valid_o/fifo_level_o update on the clock edge after the push cycle. From the pin rising edge of the 8th SCK, that is SyncStages+2 clk_sys_i cycles to rd_valid_o=1 (empty FIFO).
- FIFO:
  - Registered pointers with an extra wrap bit; full when level==FifoDepth.
  - rd_data_o is the head entry, combinational from storage; stable while rd_valid_o=1 and not popped.
  - Pop when rd_valid_o & rd_ready_i; rd_ready_i is ignored when empty.
  - Push when full with no pop that cycle: byte dropped, overflow_o←1, level unchanged.
  - Push when full with a pop the same cycle: both proceed, level unchanged, no overflow.
  - Push and pop on an empty FIFO: push only (the pop is invalid), level 0→1.
- overflow_o:
  - Cleared by clr_overflow_i.
  - If clr_overflow_i and a new overflow occur the same cycle, overflow_o stays 1.
- Reset mid-operation: async reset clears all state immediately, including FIFO contents. After reset release, capture starts only at the next cs_fall; CS already low at release is not a frame start.

Test Plan:
- Single byte: CS low, send 0xA5 with DC=1, CS high → rd_data_o=0x1A5, rd_valid_o=1 exactly SyncStages+2 cycles after the 8th SCK pin edge, fifo_level_o=1, frame_err_o never pulses.
- Multi-byte frame: one CS window with cmd 0x2A (DC=0) then data 0x00,0x7F (DC=1) → pops yield 0x02A, 0x100, 0x17F in order.
- Aborted byte: CS low, 5 SCK edges, CS high → frame_err_o pulses for exactly 1 cycle, FIFO empty; the next full byte 0x3C (DC=0) captures as 0x03C.
- Overflow: FifoDepth=8, rd_ready_i=0, send 9 bytes 0x01..0x09 → level=8, overflow_o=1, pops return 0x01..0x08 only. clr_overflow_i pulse → overflow_o=0. clr_overflow_i asserted in the same cycle as another drop → overflow_o remains 1.
- Full with simultaneous pop: FIFO full, rd_ready_i held 1 in the push cycle of byte 0x55 → no overflow, level stays 8, 0x55 (with its DC) is last out.
- Reset mid-byte: assert rst_sys_ni=0 after 4 bits, release with CS still low, then clock 8 more bits → no capture. A subsequent CS high→low and byte 0xC3 (DC=1) → 0x1C3.
